// File: rtl/display_scan_if.sv
// Signal bundle between the BCD counter side and the 3-digit scan driver.
// All signals are level-based and sampled every clock; there is no valid/ready handshake.
interface display_scan_if;
  logic       enb;
  logic       lz_blank;
  logic [6:0] bit0;
  logic [6:0] bit1;
  logic [6:0] bit2;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_tick;

  modport master (
    output enb, lz_blank, bit0, bit1, bit2,
    input  seg, an, frame_tick
  );

  modport slave (
    input  enb, lz_blank, bit0, bit1, bit2,
    output seg, an, frame_tick
  );
endinterface

// File: rtl/display_scan_3dig.sv
// Time-multiplexed scan of three 7-segment patterns onto one segment bus, with
// per-slot dead time, optional leading-zero blanking and a per-frame input snapshot.
module display_scan_3dig #(
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 16
) (
  input  logic             clk,
  input  logic             reset,
  display_scan_if.slave    bus,
  output logic [1:0]       state_dbg
);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST     = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] LIT_FROM = CW'(BLANK);
  localparam logic [6:0]    ZERO     = 7'b1111110;

  typedef enum logic [1:0] {IDLE = 2'd0, DIG0 = 2'd1, DIG1 = 2'd2, DIG2 = 2'd3} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [6:0]    sh0, sh1, sh2;
  logic [6:0]    sh0_nx, sh1_nx, sh2_nx;
  logic          load;
  logic          blank1, blank2;
  logic [6:0]    seg_q, seg_nx;
  logic [2:0]    an_q, an_nx;
  logic          ft_q, ft_nx;

  assign state_dbg      = state;
  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = ft_q;

  // Next state / slot counter; the snapshot is taken on every entry into DIG0.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    if (!bus.enb) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = DIG0;
          cnt_nx   = '0;
          load     = 1'b1;
        end
        DIG0, DIG1, DIG2: begin
          if (cnt == LAST) begin
            cnt_nx = '0;
            case (state)
              DIG0:    state_nx = DIG1;
              DIG1:    state_nx = DIG2;
              default: begin
                state_nx = DIG0;
                load     = 1'b1;
              end
            endcase
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Outputs are derived from the next-cycle state so an/seg/frame_tick can be registered.
  always_comb begin
    sh0_nx = load ? bus.bit0 : sh0;
    sh1_nx = load ? bus.bit1 : sh1;
    sh2_nx = load ? bus.bit2 : sh2;
    blank2 = bus.lz_blank && (sh2_nx == ZERO);
    blank1 = blank2 && (sh1_nx == ZERO);
    seg_nx = '0;
    an_nx  = '0;
    ft_nx  = (state_nx == DIG2) && (cnt_nx == LAST);
    if (state_nx != IDLE && cnt_nx >= LIT_FROM) begin
      case (state_nx)
        DIG0: begin
          an_nx  = 3'b001;
          seg_nx = sh0_nx;
        end
        DIG1: if (!blank1) begin
          an_nx  = 3'b010;
          seg_nx = sh1_nx;
        end
        DIG2: if (!blank2) begin
          an_nx  = 3'b100;
          seg_nx = sh2_nx;
        end
        default: begin
          an_nx  = '0;
          seg_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sh0   <= '0;
      sh1   <= '0;
      sh2   <= '0;
      seg_q <= '0;
      an_q  <= '0;
      ft_q  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sh0   <= sh0_nx;
      sh1   <= sh1_nx;
      sh2   <= sh2_nx;
      seg_q <= seg_nx;
      an_q  <= an_nx;
      ft_q  <= ft_nx;
    end
  end
endmodule

// File: tb/tb_display_scan_3dig.sv
// Bench for display_scan_3dig with PRESCALE=8, BLANK=2: vector table plus
// hand-written snapshot, enable and reset sequences, checked through an expected queue.
module tb_display_scan_3dig;
  localparam int P = 8;
  localparam int B = 2;
  localparam logic [6:0] ZERO = 7'b1111110;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIG0 = 2'd1;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         failures = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  display_scan_if bus();

  display_scan_3dig #(.PRESCALE(P), .BLANK(B)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  typedef struct packed {
    logic       lz;
    logic [6:0] p0;
    logic [6:0] p1;
    logic [6:0] p2;
    logic       bl1;
    logic       bl2;
  } vec_t;

  vec_t vecs[7];

  // Expected {an, seg, frame_tick} for a cycle counted from DIG0 entry.
  function automatic logic [10:0] exp_at(int c, logic [6:0] p0, logic [6:0] p1,
                                         logic [6:0] p2, logic bl1, logic bl2);
    int slot = (c / P) % 3;
    int off  = c % P;
    logic [2:0] an = 3'b000;
    logic [6:0] sg = 7'd0;
    logic ft = (slot == 2) && (off == P - 1);
    if (off >= B) begin
      if (slot == 0) begin an = 3'b001; sg = p0; end
      else if (slot == 1 && !bl1) begin an = 3'b010; sg = p1; end
      else if (slot == 2 && !bl2) begin an = 3'b100; sg = p2; end
    end
    return {an, sg, ft};
  endfunction

  task automatic cmp_out(string name);
    logic [10:0] act = {bus.an, bus.seg, bus.frame_tick};
    logic [10:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: queue empty, got an=%b seg=%b ft=%b", name, act[10:8], act[7:1], act[0]);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        failures++;
        $display("FAIL %s: got an=%b seg=%b ft=%b, expected an=%b seg=%b ft=%b",
                 name, act[10:8], act[7:1], act[0], exp[10:8], exp[7:1], exp[0]);
      end
    end
  endtask

  task automatic cmp_state(string name, logic [1:0] exp);
    checks++;
    if (state_dbg !== exp) begin
      failures++;
      $display("FAIL %s: got state=%0d, expected state=%0d", name, state_dbg, exp);
    end
  endtask

  // Drop enb for two cycles, check dark, then present new inputs and raise enb.
  task automatic restart(logic [6:0] p0, logic [6:0] p1, logic [6:0] p2, logic lz);
    @(negedge clk);
    bus.enb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(11'd0);
    cmp_out("idle_dark");
    cmp_state("idle_state", ST_IDLE);
    bus.bit0 = p0;
    bus.bit1 = p1;
    bus.bit2 = p2;
    bus.lz_blank = lz;
    bus.enb = 1'b1;
  endtask

  initial begin
    logic [6:0] a0, a1, a2, na, nb;
    a0 = 7'b1001111;
    a1 = 7'b1101101;
    a2 = 7'b1111001;
    na = 7'b0110011;
    nb = 7'b0000110;

    vecs[0] = '{lz: 1'b0, p0: a0, p1: a1, p2: a2, bl1: 1'b0, bl2: 1'b0};
    vecs[1] = '{lz: 1'b1, p0: ZERO, p1: ZERO, p2: ZERO, bl1: 1'b1, bl2: 1'b1};
    vecs[2] = '{lz: 1'b1, p0: 7'b0110000, p1: 7'b1011011, p2: ZERO, bl1: 1'b0, bl2: 1'b1};
    vecs[3] = '{lz: 1'b1, p0: 7'b1111011, p1: ZERO, p2: 7'b1001111, bl1: 1'b0, bl2: 1'b0};
    vecs[4] = '{lz: 1'b0, p0: ZERO, p1: ZERO, p2: ZERO, bl1: 1'b0, bl2: 1'b0};
    vecs[5] = '{lz: 1'b1, p0: 7'b1111111, p1: 7'b1111111, p2: 7'b1111111, bl1: 1'b0, bl2: 1'b0};
    vecs[6] = '{lz: 1'b1, p0: 7'b1011011, p1: ZERO, p2: 7'b0110000, bl1: 1'b0, bl2: 1'b0};

    reset = 1'b1;
    bus.enb = 1'b0;
    bus.lz_blank = 1'b0;
    bus.bit0 = a0;
    bus.bit1 = a1;
    bus.bit2 = a2;
    repeat (3) @(negedge clk);
    exp_q.push_back(11'd0);
    cmp_out("reset_outputs");
    cmp_state("reset_state", ST_IDLE);
    reset = 1'b0;

    // Table: two full frames per vector
    for (int v = 0; v < 7; v++) begin
      restart(vecs[v].p0, vecs[v].p1, vecs[v].p2, vecs[v].lz);
      for (int c = 0; c < 6 * P; c++)
        exp_q.push_back(exp_at(c, vecs[v].p0, vecs[v].p1, vecs[v].p2, vecs[v].bl1, vecs[v].bl2));
      for (int c = 0; c < 6 * P; c++) begin
        @(negedge clk);
        if (c == 0) cmp_state($sformatf("vec%0d_entry", v), ST_DIG0);
        cmp_out($sformatf("vec%0d_c%0d", v, c));
      end
    end

    // Snapshot: mid-frame change ignored, change on the DIG0-entry edge captured
    restart(a0, a1, a2, 1'b0);
    for (int c = 0; c < 9 * P; c++)
      exp_q.push_back(exp_at(c % (3 * P), a0, (c < 3 * P) ? a1 : (c < 6 * P) ? na : nb, a2, 1'b0, 1'b0));
    for (int c = 0; c < 9 * P; c++) begin
      @(negedge clk);
      cmp_out($sformatf("snap_c%0d", c));
      if (c == 12) bus.bit1 = na;
      if (c == 6 * P - 1) bus.bit1 = nb;
    end

    // Enable drop mid-slot, re-enable with fresh inputs, then drop on frame boundary
    restart(a0, a1, a2, 1'b0);
    for (int c = 0; c < 37; c++) begin
      if (c < 5) exp_q.push_back(exp_at(c, a0, a1, a2, 1'b0, 1'b0));
      else if (c < 10) exp_q.push_back(11'd0);
      else if (c < 34) exp_q.push_back(exp_at(c - 10, nb, na, a1, 1'b0, 1'b0));
      else exp_q.push_back(11'd0);
    end
    for (int c = 0; c < 37; c++) begin
      @(negedge clk);
      cmp_out($sformatf("enb_c%0d", c));
      if (c == 4) begin
        bus.enb = 1'b0;
        bus.bit0 = 7'b0000001;
      end
      if (c == 9) begin
        bus.bit0 = nb;
        bus.bit1 = na;
        bus.bit2 = a1;
        bus.enb = 1'b1;
      end
      if (c == 10) cmp_state("reenter_dig0", ST_DIG0);
      if (c == 33) bus.enb = 1'b0;
    end

    // Asynchronous reset in the middle of a lit tens slot
    restart(a0, a1, a2, 1'b0);
    for (int c = 0; c < 13; c++) exp_q.push_back(exp_at(c, a0, a1, a2, 1'b0, 1'b0));
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      cmp_out($sformatf("prerst_c%0d", c));
    end
    #1 reset = 1'b1;
    #1;
    exp_q.push_back(11'd0);
    cmp_out("async_reset_dark");
    cmp_state("async_reset_state", ST_IDLE);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3 * P; c++) exp_q.push_back(exp_at(c, a0, a1, a2, 1'b0, 1'b0));
    for (int c = 0; c < 3 * P; c++) begin
      @(negedge clk);
      if (c == 0) cmp_state("post_reset_dig0", ST_DIG0);
      cmp_out($sformatf("postrst_c%0d", c));
    end

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drained: got %0d leftover entries, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/display_scan_3dig.md
# display_scan_3dig

Time-multiplexed driver for a three-digit common-anode/common-cathode 7-segment display. It consumes the three segment patterns produced by the 0–999 BCD counter (ones, tens, hundreds) and scans them onto a single shared segment bus with one-hot digit enables. Each digit slot begins with a dead-time interval to prevent ghosting. Optional leading-zero blanking is supported. A per-frame input snapshot prevents torn digits.

## Interface
- PRESCALE, default 1000: clk cycles per digit slot; legal range ≥ 2.
- BLANK, default 16: dead-time cycles at the start of each slot; legal range 0 ≤ BLANK < PRESCALE.
- clk  input  1  system clock, rising edge.
- reset  input  1  reset, asynchronous, active-high.
- enb  input  1  scan enable; low forces the display dark.
- lz_blank  input  1  leading-zero blanking enable.
- bit0  input  7  ones-digit pattern, {a,b,c,d,e,f,g}, active-high; zero = 7'b1111110.
- bit1  input  7  tens-digit pattern, same encoding.
- bit2  input  7  hundreds-digit pattern, same encoding.
- seg  output  7  shared segment bus, same encoding; 0 = dark.
- an  output  3  one-hot digit enable, active-high; an[0]=ones, an[1]=tens, an[2]=hundreds.
- frame_tick  output  1  one-cycle pulse on the last cycle of the hundreds slot.

## Operation
- State machine states: IDLE, DIG0, DIG1, DIG2. Slot counter cnt runs 0..PRESCALE-1 and is cleared on every state change.
- Transitions:
  - IDLE→DIG0 on the first edge where enb=1.
  - DIG0→DIG1→DIG2→DIG0 on the edge where cnt=PRESCALE-1.
  - Any state→IDLE on any edge where enb=0.
- Snapshot: sh0/sh1/sh2 are loaded from bit0/bit1/bit2 on every edge that enters DIG0, whether from IDLE or from DIG2. Input changes at any other time have no effect until the next DIG0 entry.
- Leading-zero blanking, when lz_blank=1 at slot time:
  - Hundreds digit blanked if sh2=7'b1111110.
  - Tens digit blanked if sh2 and sh1 are both 7'b1111110.
  - Ones digit is never blanked.
  - An inner zero (e.g. 105) is always shown.
  - A blanked slot keeps full slot timing with an=000 and seg=0.
- Outputs per cycle:
  - IDLE, or cnt<BLANK: an=000, seg=0.
  - Otherwise: an=one-hot of the current digit and seg=shN, unless that digit is blanked.
  - frame_tick=1 only in DIG2 with cnt=PRESCALE-1, whether or not DIG2 is blanked.
- seg and an must never be nonzero with a mismatched digit, including across slot boundaries.
- No arithmetic on pattern data: patterns pass through unmodified, including the default/invalid pattern 7'b1111111.

## Timing
- Reset (asynchronous, any time, including mid-slot): state=IDLE, cnt=0, sh0..sh2=0, seg=0, an=000, frame_tick=0. The first active slot starts on the first edge with enb=1 after reset deasserts.
- an, seg and frame_tick are registered with no combinational path from inputs. Their values in a given cycle correspond to that cycle's state/cnt, computed one edge ahead.
- Enable latency: enb sampled high at edge k puts the block in DIG0 with cnt=0 after edge k. The ones digit lights BLANK cycles later, or immediately if BLANK=0.
- Disable latency: enb sampled low at edge k gives an=000 and seg=0 after edge k.
- Frame length: 3×PRESCALE cycles. frame_tick period is 3×PRESCALE while enb stays high.
- Simultaneous events:
  - enb=0 at the DIG2→DIG0 boundary: goes to IDLE and takes no snapshot.
  - Input change on the same edge as DIG0 entry: the new values are captured.

## Test plan
Scenarios 1–5 use PRESCALE=8, BLANK=2.

1. Reset mid-DIG1 slot with seg nonzero → seg=0, an=000, frame_tick=0 immediately, with no clock required. After release and enb=1, DIG0 starts with cnt=0.
2. bit0=7'b1001111, bit1=7'b1101101, bit2=7'b1111001, lz_blank=0, enb rises → relative cycles:
   - 0–1: an=000.
   - 2–7: an=001, seg=1001111.
   - 8–9: dark.
   - 10–15: an=010, seg=1101101.
   - 18–23: an=100, seg=1111001.
   - frame_tick=1 only at cycle 23; pattern repeats from cycle 24.
3. lz_blank=1, all three patterns = 7'b1111110 → only an=001 with seg=1111110 in cycles 2–7. Slots 1 and 2 stay dark. frame_tick still fires at cycle 23.
4. lz_blank=1 with sh2=1111110, sh1=1011011 → tens shown, hundreds dark. With sh2=1001111, sh1=1111110 → tens shown as zero.
5. Change bit1 to 7'b0110011 at cycle 12 → tens slot still shows 1101101. The next frame shows 0110011.
6. enb low at cycle 4 → cycle 5 dark. enb high at cycle 9 → DIG0 re-entered with cnt=0, a fresh snapshot, and ones lit from cycle 12.
